dram_model_chk: RTL and testbench

Parametrised DRAM model with a built-in result checker for the CNN accelerator bench. It serves the accelerator's read/write port with a configurable read latency and per-lane write strobes, and holds a golden image for the output region. On trigger, it scans that region lane by lane with an absolute-difference tolerance and reports pass and error counts plus the run's cycle count. It sits between `Top` and the bench and replaces ad-hoc memory arrays and compare loops.

---
 rtl/dram_model_chk.sv | 187 ++++++++++++++++++
 tb/tb_dram_model_chk.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_model_chk.sv
// +----------------------------------------------------------------------------+
// | Module   : dram_model_chk                                                  |
// | Brief    : 1W/2R DRAM model with RD_LAT read pipeline, per-lane strobes,   |
// |            and a golden-image result checker compiled in by DRAM_CHK_EN.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module dram_model_chk #(
  parameter int DATA_W    = 64,
  parameter int LANE_W    = 8,
  parameter int ADDR_W    = 10,
  parameter int RD_LAT    = 1,
  parameter int TOL       = 2,
  parameter int CHK_BASE  = 238,
  parameter int CHK_LEN   = 150,
  parameter int TRIG_ADDR = 398,
  parameter int CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rd_en,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [DATA_W/LANE_W-1:0]   wr_strb,
  input  logic                       gold_we,
  input  logic [ADDR_W-1:0]          gold_addr,
  input  logic [DATA_W-1:0]          gold_data,
  input  logic                       chk_start,
  output logic                       chk_busy,
  output logic                       chk_done,
  output logic [CNT_W-1:0]           pass_cnt,
  output logic [CNT_W-1:0]           err_cnt,
  output logic [31:0]                cycle_cnt
);

  localparam int LANES = DATA_W / LANE_W;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_pipe_data [RD_LAT];
  logic [RD_LAT-1:0] r_pipe_vld;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_strb[i]) r_mem[wr_addr][i*LANE_W +: LANE_W] <= wr_data[i*LANE_W +: LANE_W];
      end
    end
  end

  // Each stage only loads on valid so the last stage holds its data between reads.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pipe_vld <= '0;
      for (int j = 0; j < RD_LAT; j++) r_pipe_data[j] <= '0;
    end else begin
      r_pipe_vld[0] <= rd_en;
      if (rd_en) r_pipe_data[0] <= r_mem[rd_addr];
      for (int j = 1; j < RD_LAT; j++) begin
        r_pipe_vld[j] <= r_pipe_vld[j-1];
        if (r_pipe_vld[j-1]) r_pipe_data[j] <= r_pipe_data[j-1];
      end
    end
  end

  assign rd_data  = r_pipe_data[RD_LAT-1];
  assign rd_valid = r_pipe_vld[RD_LAT-1];

`ifdef DRAM_CHK_EN
  localparam int GIDX_W = (CHK_LEN > 1) ? $clog2(CHK_LEN) : 1;
  localparam int K_W    = $clog2(CHK_LEN + 1);
  localparam int PC_W   = $clog2(LANES + 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t              r_state, w_next;
  logic [DATA_W-1:0]   r_gold [CHK_LEN];
  logic [K_W-1:0]      r_k;
  logic [DATA_W-1:0]   r_scan_mem, r_scan_gold;
  logic                r_scan_vld, r_scan_last;
  logic [CNT_W-1:0]    r_pass, r_err;
  logic [31:0]         r_cycle;
  logic                w_trig, w_enter, w_issue;
  logic [ADDR_W-1:0]   w_scan_addr;
  logic [LANE_W-1:0]   w_diff;
  logic [PC_W-1:0]     w_pass_lanes, w_err_lanes;
  logic [CNT_W:0]      w_pass_sum, w_err_sum;

  always_ff @(posedge clk) begin
    if (gold_we && (int'(gold_addr) < CHK_LEN)) r_gold[gold_addr[GIDX_W-1:0]] <= gold_data;
  end

  assign w_trig      = chk_start | (wr_en & (wr_addr == ADDR_W'(TRIG_ADDR)));
  assign w_enter     = w_trig & (r_state != S_SCAN);
  assign w_issue     = (r_state == S_SCAN) && (r_k < K_W'(CHK_LEN));
  assign w_scan_addr = ADDR_W'(CHK_BASE) + ADDR_W'(r_k);

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_trig) w_next = S_SCAN;
      S_SCAN:  if (r_scan_vld && r_scan_last) w_next = S_DONE;
      S_DONE:  if (w_trig) w_next = S_SCAN;
      default: w_next = S_IDLE;
    endcase
  end

  // Scan port: issue one word per cycle, compare one cycle later.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_k         <= '0;
      r_scan_vld  <= 1'b0;
      r_scan_last <= 1'b0;
    end else begin
      r_scan_vld  <= w_issue;
      r_scan_last <= w_issue && (r_k == K_W'(CHK_LEN - 1));
      if (w_enter)      r_k <= '0;
      else if (w_issue) r_k <= r_k + K_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_scan_mem  <= r_mem[w_scan_addr];
      r_scan_gold <= r_gold[r_k[GIDX_W-1:0]];
    end
  end

  always_comb begin
    w_pass_lanes = '0;
    w_diff       = '0;
    for (int i = 0; i < LANES; i++) begin
      if (r_scan_mem[i*LANE_W +: LANE_W] >= r_scan_gold[i*LANE_W +: LANE_W])
        w_diff = r_scan_mem[i*LANE_W +: LANE_W] - r_scan_gold[i*LANE_W +: LANE_W];
      else
        w_diff = r_scan_gold[i*LANE_W +: LANE_W] - r_scan_mem[i*LANE_W +: LANE_W];
      if (int'(w_diff) <= TOL) w_pass_lanes = w_pass_lanes + PC_W'(1);
    end
  end

  assign w_err_lanes = PC_W'(LANES) - w_pass_lanes;
  assign w_pass_sum  = {1'b0, r_pass} + (CNT_W+1)'(w_pass_lanes);
  assign w_err_sum   = {1'b0, r_err}  + (CNT_W+1)'(w_err_lanes);

  always_ff @(posedge clk) begin
    if (!rst || w_enter) begin
      r_pass <= '0;
      r_err  <= '0;
    end else if ((r_state == S_SCAN) && r_scan_vld) begin
      r_pass <= w_pass_sum[CNT_W] ? '1 : w_pass_sum[CNT_W-1:0];
      r_err  <= w_err_sum[CNT_W]  ? '1 : w_err_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) r_cycle <= '0;
    else if ((r_state != S_DONE) && (r_cycle != '1)) r_cycle <= r_cycle + 32'd1;
  end

  assign chk_busy  = (r_state == S_SCAN);
  assign chk_done  = (r_state == S_DONE);
  assign pass_cnt  = r_pass;
  assign err_cnt   = r_err;
  assign cycle_cnt = r_cycle;
`else
  logic w_unused;
  assign w_unused  = ^{gold_we, gold_addr, gold_data, chk_start};
  assign chk_busy  = 1'b0;
  assign chk_done  = 1'b0;
  assign pass_cnt  = '0;
  assign err_cnt   = '0;
  assign cycle_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dram_model_chk.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_dram_model_chk                                               |
// | Brief    : Directed bench for dram_model_chk (RD_LAT 1 and 3 instances).   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_dram_model_chk;

  logic        clk, rst;
  logic        rd_en, wr_en, gold_we, chk_start;
  logic [9:0]  rd_addr, wr_addr, gold_addr;
  logic [63:0] wr_data, gold_data;
  logic [7:0]  wr_strb;

  logic [63:0] rd_data1, rd_data3;
  logic        rd_valid1, rd_valid3, busy1, busy3, done1, done3;
  logic [15:0] pass1, pass3, err1, err3;
  logic [31:0] cyc1, cyc3;

  int n_pass = 0;
  int n_total = 0;

  dram_model_chk #(.RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
    .rd_valid(rd_valid1), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_strb(wr_strb), .gold_we(gold_we), .gold_addr(gold_addr), .gold_data(gold_data),
    .chk_start(chk_start), .chk_busy(busy1), .chk_done(done1), .pass_cnt(pass1),
    .err_cnt(err1), .cycle_cnt(cyc1)
  );

  dram_model_chk #(.RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data3),
    .rd_valid(rd_valid3), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_strb(wr_strb), .gold_we(gold_we), .gold_addr(gold_addr), .gold_data(gold_data),
    .chk_start(chk_start), .chk_busy(busy3), .chk_done(done3), .pass_cnt(pass3),
    .err_cnt(err3), .cycle_cnt(cyc3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [9:0]  wa;
    logic [63:0] wd;
    logic [7:0]  ws;
    logic        re;
    logic [9:0]  ra;
    logic        ev;
    logic [63:0] ed;
  } vec_t;

  vec_t vt [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle_inputs();
    rd_en = 0; rd_addr = '0; wr_en = 0; wr_addr = '0; wr_data = '0; wr_strb = '0;
    gold_we = 0; gold_addr = '0; gold_data = '0; chk_start = 0;
  endtask

`ifdef DRAM_CHK_EN
  int tb_cyc;
  always @(posedge clk) begin
    if (!rst) tb_cyc <= 0;
    else      tb_cyc <= tb_cyc + 1;
  end

  function automatic logic [63:0] gword(input int k);
    logic [63:0] w;
    w = '0;
    for (int l = 0; l < 8; l++) w[l*8 +: 8] = 8'((k*8 + l*31) & 255);
    return w;
  endfunction

  // Word 10 lane 3 is +2 (pass), word 77 lane 5 is -3 (3 -> 0, error).
  function automatic logic [63:0] mword(input int k);
    logic [63:0] w;
    w = gword(k);
    if (k == 10) w[31:24] = w[31:24] + 8'd2;
    if (k == 77) w[47:40] = w[47:40] - 8'd3;
    return w;
  endfunction

  task automatic run_scan(input string tag, input bit by_start, input bit by_wr,
                          input int poke_at, input bit exact_cyc);
    int n;
    logic [31:0] c0;
    chk_start = by_start;
    if (by_wr) begin
      wr_en = 1; wr_addr = 10'd398; wr_data = 64'hA5A5_5A5A_0F0F_F0F0; wr_strb = 8'hFF;
    end
    tick();
    chk_start = 0; wr_en = 0;
    check({tag, "_busy_after_trig"}, 64'(busy1), 64'd1);
    n = 0;
    while (!done1 && n < 400) begin
      chk_start = (n == poke_at);
      tick();
      n++;
    end
    chk_start = 0;
    check({tag, "_done_latency"}, 64'(n), 64'd151);
    check({tag, "_pass_cnt"}, 64'(pass1), 64'd1199);
    check({tag, "_err_cnt"}, 64'(err1), 64'd1);
    check({tag, "_busy_at_done"}, 64'(busy1), 64'd0);
    if (exact_cyc) check({tag, "_cycle_cnt"}, 64'(cyc1), 64'(tb_cyc));
    c0 = cyc1;
    repeat (4) tick();
    check({tag, "_done_held"}, 64'(done1), 64'd1);
    check({tag, "_pass_held"}, 64'(pass1), 64'd1199);
    check({tag, "_cycle_frozen"}, 64'(cyc1), 64'(c0));
  endtask
`endif

  initial begin
    rst = 0;
    idle_inputs();
    repeat (3) tick();
    check("rst_rd_valid1", 64'(rd_valid1), 64'd0);
    check("rst_rd_data1", rd_data1, 64'd0);
    check("rst_rd_valid3", 64'(rd_valid3), 64'd0);
    check("rst_busy", 64'(busy1), 64'd0);
    check("rst_done", 64'(done1), 64'd0);
    check("rst_pass", 64'(pass1), 64'd0);
    check("rst_err", 64'(err1), 64'd0);
    check("rst_cycle", 64'(cyc1), 64'd0);
    rst = 1;

    vt[0] = '{1'b1, 10'd5, 64'h0123456789ABCDEF, 8'hFF, 1'b0, 10'd0, 1'b0, 64'h0};
    vt[1] = '{1'b0, 10'd0, 64'h0, 8'h00, 1'b1, 10'd5, 1'b1, 64'h0123456789ABCDEF};
    vt[2] = '{1'b0, 10'd0, 64'h0, 8'h00, 1'b0, 10'd0, 1'b0, 64'h0123456789ABCDEF};
    vt[3] = '{1'b1, 10'd9, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b0, 10'd0, 1'b0, 64'h0123456789ABCDEF};
    vt[4] = '{1'b1, 10'd9, 64'h0, 8'h0F, 1'b1, 10'd9, 1'b1, 64'hFFFFFFFFFFFFFFFF};
    vt[5] = '{1'b0, 10'd0, 64'h0, 8'h00, 1'b1, 10'd9, 1'b1, 64'hFFFFFFFF00000000};
    vt[6] = '{1'b1, 10'd5, 64'h0, 8'h81, 1'b1, 10'd5, 1'b1, 64'h0123456789ABCDEF};
    vt[7] = '{1'b0, 10'd0, 64'h0, 8'h00, 1'b1, 10'd5, 1'b1, 64'h0023456789ABCD00};
    vt[8] = '{1'b0, 10'd0, 64'h0, 8'h00, 1'b0, 10'd0, 1'b0, 64'h0023456789ABCD00};

    for (int i = 0; i < 9; i++) begin
      wr_en = vt[i].we; wr_addr = vt[i].wa; wr_data = vt[i].wd; wr_strb = vt[i].ws;
      rd_en = vt[i].re; rd_addr = vt[i].ra;
      tick();
      check($sformatf("vec%0d_rd_valid", i), 64'(rd_valid1), 64'(vt[i].ev));
      check($sformatf("vec%0d_rd_data", i), rd_data1, vt[i].ed);
    end
    idle_inputs();

    // Latency sweep on the RD_LAT=3 instance.
    wr_en = 1; wr_addr = 10'd5; wr_data = 64'h0123456789ABCDEF; wr_strb = 8'hFF;
    tick();
    idle_inputs();
    repeat (3) tick();
    rd_en = 1; rd_addr = 10'd5;
    tick();
    rd_en = 0;
    check("lat1_valid", 64'(rd_valid1), 64'd1);
    check("lat1_data", rd_data1, 64'h0123456789ABCDEF);
    check("lat3_valid_c1", 64'(rd_valid3), 64'd0);
    check("lat3_hold_c1", rd_data3, 64'h0023456789ABCD00);
    tick();
    check("lat1_valid_pulse", 64'(rd_valid1), 64'd0);
    check("lat3_valid_c2", 64'(rd_valid3), 64'd0);
    tick();
    check("lat3_valid_c3", 64'(rd_valid3), 64'd1);
    check("lat3_data_c3", rd_data3, 64'h0123456789ABCDEF);
    tick();
    check("lat3_valid_c4", 64'(rd_valid3), 64'd0);
    check("lat3_hold_c4", rd_data3, 64'h0123456789ABCDEF);

`ifdef DRAM_CHK_EN
    for (int k = 0; k < 150; k++) begin
      wr_en = 1; wr_addr = 10'(238 + k); wr_data = mword(k); wr_strb = 8'hFF;
      gold_we = 1; gold_addr = 10'(k); gold_data = gword(k);
      tick();
    end
    idle_inputs();
    // Out-of-range golden write whose low bits alias index 10.
    gold_we = 1; gold_addr = 10'd266; gold_data = 64'h0;
    tick();
    idle_inputs();
    check("idle_before_scan", 64'(busy1), 64'd0);

    run_scan("start", 1'b1, 1'b0, -1, 1'b1);
    run_scan("autotrig", 1'b0, 1'b1, 50, 1'b0);

    // Simultaneous start + trigger write, then reset mid-scan.
    chk_start = 1; wr_en = 1; wr_addr = 10'd398; wr_data = 64'h1; wr_strb = 8'hFF;
    tick();
    idle_inputs();
    check("both_trig_busy", 64'(busy1), 64'd1);
    repeat (40) tick();
    rst = 0;
    tick();
    check("midrst_busy", 64'(busy1), 64'd0);
    check("midrst_done", 64'(done1), 64'd0);
    check("midrst_pass", 64'(pass1), 64'd0);
    check("midrst_err", 64'(err1), 64'd0);
    check("midrst_cycle", 64'(cyc1), 64'd0);
    check("midrst_rd_data", rd_data1, 64'd0);
    rst = 1;
    repeat (3) tick();
    check("midrst_idle_busy", 64'(busy1), 64'd0);
    check("midrst_idle_done", 64'(done1), 64'd0);
    run_scan("retrig", 1'b1, 1'b0, -1, 1'b1);
`else
    wr_en = 1; wr_addr = 10'd398; wr_data = 64'hDEADBEEFCAFEF00D; wr_strb = 8'hFF;
    chk_start = 1;
    tick();
    idle_inputs();
    repeat (5) tick();
    check("off_busy", 64'(busy1), 64'd0);
    check("off_done", 64'(done1), 64'd0);
    check("off_pass", 64'(pass1), 64'd0);
    check("off_err", 64'(err1), 64'd0);
    check("off_cycle", 64'(cyc1), 64'd0);
    rd_en = 1; rd_addr = 10'd398;
    tick();
    rd_en = 0;
    check("off_rd_valid", 64'(rd_valid1), 64'd1);
    check("off_rd_data", rd_data1, 64'hDEADBEEFCAFEF00D);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
